// File: rtl/sub_pkg.sv
// Shared types and constants for the subtract-datapath arbiter.
package sub_pkg;

    // Default operand/result width.
    localparam int WIDTH = 16;

    // Sequencer states: grant, invert b, add, hold result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Requester index (two requesters).
    typedef logic req_id_t;

    // Saturation limits for a WIDTH-bit signed result.
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/sub_arbiter_if.sv
// Request/response bundle between the two loop stages and the subtract arbiter.
interface sub_arbiter_if #(
    parameter int WIDTH = sub_pkg::WIDTH
);
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;
    logic             rsp_id;

    // Requesters and result consumer.
    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_id
    );

    // The arbiter serving the requests.
    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_id
    );
endinterface

// File: rtl/ones_cpl.sv
// Bitwise one's-complement inverter: first half of the shared subtractor.
module ones_cpl #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    assign q_o = ~d_i;
endmodule

// File: rtl/sub_arbiter.sv
// Two-requester round-robin arbiter sequencing a - b over the shared
// inverter/adder pair; holds the tagged result until the consumer accepts it.
module sub_arbiter
    import sub_pkg::*;
#(
    parameter int WIDTH = sub_pkg::WIDTH,
    parameter bit SAT   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    sub_arbiter_if.slave  bus
);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    req_id_t          last_grant_q;
    req_id_t          id_q;
    logic [WIDTH-1:0] a_q, b_q, b_n_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_ovf_q;
    req_id_t          rsp_id_q;

    logic             grant_valid_s;
    req_id_t          grant_id_s;
    logic [1:0]       req_ready_s;
    logic             load_s;
    logic             rsp_valid_s;
    logic [WIDTH-1:0] b_inv_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;
    logic [WIDTH-1:0] res_s;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        case (bus.req_valid)
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_id_s    = ~last_grant_q;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_id_s    = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    state_d = NEG;
                end else begin
                    state_d = IDLE;
                end
            end
            NEG:  state_d = ADD;
            ADD:  state_d = DONE;
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: grant strobe only in IDLE, result valid only in DONE.
    always_comb begin
        req_ready_s = 2'b00;
        load_s      = 1'b0;
        rsp_valid_s = (state_q == DONE);
        if ((state_q == IDLE) && grant_valid_s) begin
            load_s      = 1'b1;
            req_ready_s = grant_id_s ? 2'b10 : 2'b01;
        end else begin
            load_s      = 1'b0;
            req_ready_s = 2'b00;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.rsp_id    = rsp_id_q;

    ones_cpl #(.WIDTH(WIDTH)) u_ones_cpl (
        .d_i (b_q),
        .q_o (b_inv_s)
    );

    // Two's-complement add with carry-in 1, overflow detect and optional clamp.
    always_comb begin
        sum_s = a_q + b_n_q + ONE;
        ovf_s = (a_q[MSB] != b_q[MSB]) && (sum_s[MSB] != a_q[MSB]);
        if (SAT && ovf_s) begin
            res_s = a_q[MSB] ? SAT_LO : SAT_HI;
        end else begin
            res_s = sum_s;
        end
    end

    // Operand capture on grant; later operand changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (load_s) begin
            a_q  <= grant_id_s ? bus.req_a1 : bus.req_a0;
            b_q  <= grant_id_s ? bus.req_b1 : bus.req_b0;
            id_q <= grant_id_s;
        end
    end

    // Inverter step: latch ~b during NEG.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_n_q <= '0;
        end else if (state_q == NEG) begin
            b_n_q <= b_inv_s;
        end
    end

    // Result registers loaded at the end of ADD and held through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else if (state_q == ADD) begin
            rsp_data_q <= res_s;
            rsp_ovf_q  <= ovf_s;
            rsp_id_q   <= id_q;
        end
    end

    // Round-robin history updates only once the result is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if ((state_q == DONE) && bus.rsp_ready) begin
            last_grant_q <= rsp_id_q;
        end
    end

endmodule

// File: tb/tb_sub_arbiter.sv
// Scoreboard bench: two arbiters (wrap and saturate) driven with identical
// directed vectors; expected responses are queued when stimulus is issued
// and a monitor pops/compares on every response handshake.
module tb_sub_arbiter;
    import sub_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [17:0] q0[$];
    logic [17:0] q1[$];

    sub_arbiter_if #(.WIDTH(16)) i0 ();
    sub_arbiter_if #(.WIDTH(16)) i1 ();

    assign i1.req_valid = i0.req_valid;
    assign i1.req_a0    = i0.req_a0;
    assign i1.req_a1    = i0.req_a1;
    assign i1.req_b0    = i0.req_b0;
    assign i1.req_b1    = i0.req_b1;
    assign i1.rsp_ready = i0.rsp_ready;

    sub_arbiter #(.WIDTH(16), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
    sub_arbiter #(.WIDTH(16), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each accepted response with the queued expectation.
    always @(negedge clk) begin : mon
        logic [17:0] e;
        if (i0.rsp_valid && i0.rsp_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_wrap_unexpected act=%h exp=none", {i0.rsp_id, i0.rsp_ovf, i0.rsp_data});
            end else begin
                e = q0.pop_front();
                chk("sb_wrap_rsp", {14'd0, i0.rsp_id, i0.rsp_ovf, i0.rsp_data}, {14'd0, e});
            end
        end
        if (i1.rsp_valid && i1.rsp_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_sat_unexpected act=%h exp=none", {i1.rsp_id, i1.rsp_ovf, i1.rsp_data});
            end else begin
                e = q1.pop_front();
                chk("sb_sat_rsp", {14'd0, i1.rsp_id, i1.rsp_ovf, i1.rsp_data}, {14'd0, e});
            end
        end
    end

    task automatic expect_rsp(input logic id, input logic [15:0] dw, input logic [15:0] ds, input logic ovf);
        q0.push_back({id, ovf, dw});
        q1.push_back({id, ovf, ds});
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_rsp_valid"}, {31'd0, i0.rsp_valid}, 32'd0);
        chk({nm, "_req_ready"}, {30'd0, i0.req_ready}, 32'd0);
        chk({nm, "_rsp_data"},  {16'd0, i0.rsp_data},  32'd0);
        chk({nm, "_rsp_ovf"},   {31'd0, i0.rsp_ovf},   32'd0);
        chk({nm, "_rsp_id"},    {31'd0, i0.rsp_id},    32'd0);
        chk({nm, "_sat_rsp_valid"}, {31'd0, i1.rsp_valid}, 32'd0);
        chk({nm, "_sat_rsp_data"},  {16'd0, i1.rsp_data},  32'd0);
    endtask

    task automatic wait_grant(input logic [1:0] exp_rr, input string nm);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (i0.req_ready != 2'b00) break;
        end
        chk(nm, {30'd0, i0.req_ready}, {30'd0, exp_rr});
        chk({nm, "_sat"}, {30'd0, i1.req_ready}, {30'd0, exp_rr});
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        chk(nm, q0.size() + q1.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // Single request with latency checks; entered and left just after a rising edge.
    task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] dw, input logic [15:0] ds, input logic ovf);
        expect_rsp(id, dw, ds, ovf);
        if (id) begin
            i0.req_a1 = a; i0.req_b1 = b; i0.req_valid = 2'b10;
        end else begin
            i0.req_a0 = a; i0.req_b0 = b; i0.req_valid = 2'b01;
        end
        wait_grant(id ? 2'b10 : 2'b01, "grant");
        @(posedge clk); #1;
        i0.req_valid = 2'b00;
        i0.req_a0 = 16'hDEAD; i0.req_b0 = 16'hBEEF;
        i0.req_a1 = 16'hDEAD; i0.req_b1 = 16'hBEEF;
        @(posedge clk); @(negedge clk);
        chk("lat_t2_valid", {31'd0, i0.rsp_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("lat_t3_valid", {31'd0, i0.rsp_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int   n;
        int   cyc[3];
        logic gid[3];

        i0.req_valid = 2'b00;
        i0.req_a0 = 16'h0000; i0.req_b0 = 16'h0000;
        i0.req_a1 = 16'h0000; i0.req_b1 = 16'h0000;
        i0.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed single requests: id, a, b, wrap result, sat result, ovf.
        issue(1'b0, 16'h0005, 16'h0003, 16'h0002, 16'h0002, 1'b0);
        issue(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0);
        issue(1'b0, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b1);
        issue(1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b1);
        issue(1'b0, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b0);

        // Backpressure: last served was 0, so requester 1 wins the contention.
        i0.rsp_ready = 1'b0;
        i0.req_a0 = 16'h0100; i0.req_b0 = 16'h0001;
        i0.req_a1 = 16'h0010; i0.req_b1 = 16'h0020;
        expect_rsp(1'b1, 16'hFFF0, 16'hFFF0, 1'b0);
        expect_rsp(1'b0, 16'h00FF, 16'h00FF, 1'b0);
        i0.req_valid = 2'b11;
        wait_grant(2'b10, "bp_grant1");
        @(posedge clk); #1;
        i0.req_valid = 2'b01;
        @(posedge clk);
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid",     {31'd0, i0.rsp_valid}, 32'd1);
            chk("bp_data",      {16'd0, i0.rsp_data},  {16'd0, 16'hFFF0});
            chk("bp_id",        {31'd0, i0.rsp_id},    32'd1);
            chk("bp_ovf",       {31'd0, i0.rsp_ovf},   32'd0);
            chk("bp_req_ready", {30'd0, i0.req_ready}, 32'd0);
            @(posedge clk);
        end
        #1;
        i0.rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_drop", {31'd0, i0.rsp_valid}, 32'd0);
        chk("bp_grant2",     {30'd0, i0.req_ready}, 32'd1);
        @(posedge clk); #1;
        i0.req_valid = 2'b00;
        drain("bp_drain");

        // Reset during NEG abandons the op; the re-issue must be the only response.
        i0.req_a0 = 16'h0009; i0.req_b0 = 16'h0004;
        i0.req_valid = 2'b01;
        wait_grant(2'b01, "mid_grant");
        @(posedge clk); #1;
        i0.req_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1'b0, 16'h0009, 16'h0004, 16'h0005, 16'h0005, 1'b0);
        drain("mid_drain");

        // Contention from reset: grants alternate 0,1,0 every 4 cycles.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        i0.req_a0 = 16'h0100; i0.req_b0 = 16'h0001;
        i0.req_a1 = 16'h0003; i0.req_b1 = 16'h0007;
        expect_rsp(1'b0, 16'h00FF, 16'h00FF, 1'b0);
        expect_rsp(1'b1, 16'hFFFC, 16'hFFFC, 1'b0);
        expect_rsp(1'b0, 16'h00FF, 16'h00FF, 1'b0);
        i0.req_valid = 2'b11;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (i0.req_ready != 2'b00) begin
                cyc[n] = c;
                gid[n] = i0.req_ready[1];
                n++;
            end
        end
        @(posedge clk); #1;
        i0.req_valid = 2'b00;
        chk("cont_grants", n, 32'd3);
        if (n == 3) begin
            chk("cont_id0", {31'd0, gid[0]}, 32'd0);
            chk("cont_id1", {31'd0, gid[1]}, 32'd1);
            chk("cont_id2", {31'd0, gid[2]}, 32'd0);
            chk("cont_gap1", cyc[1] - cyc[0], 32'd4);
            chk("cont_gap2", cyc[2] - cyc[1], 32'd4);
        end
        drain("cont_drain");

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sub_arbiter.md
# sub_arbiter

Two-requester round-robin arbiter and sequencer for the shared 16-bit subtract datapath: a one's-complement inverter followed by an adder with carry-in 1, computing a - b in two's complement. Sits between the delta-sigma loop stages (e.g. integrator error and feedback paths) and the single inverter/adder pair. It grants one request at a time, runs the invert and add steps over successive cycles, and holds the tagged result until the consumer accepts it.

## Interface
- WIDTH, 16, operand/result width in bits.
- SAT, 0, 1 = saturate result on signed overflow; 0 = wrap.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_a0, req_a1  in  WIDTH  minuend for requester 0 and 1.
- req_b0, req_b1  in  WIDTH  subtrahend for requester 0 and 1.
- req_ready  out  2  one-hot grant/accept strobe; operands are captured on the cycle it is high.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH  a - b, signed, wrapped or saturated according to SAT.
- rsp_ovf  out  1  signed overflow occurred; reported in both SAT modes.
- rsp_id  out  1  index of the requester that owns the result.

## Operation
- FSM states: IDLE, NEG, ADD, DONE.
- IDLE:
  - If any req_valid bit is set, grant one requester and drive the matching req_ready bit high combinationally in this cycle.
  - Capture a, b and id; go to NEG.
  - If no request, stay in IDLE.
- Round-robin: the requester not granted last time has priority when both are valid. After reset, requester 0 has priority (last_grant resets to 1).
- NEG: b_n <= ~b through the inverter sub-module; go to ADD.
- ADD: sum = a + b_n + 1, truncated to WIDTH.
  - ovf = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]).
  - If SAT=1 and ovf: rsp_data = a[MSB] ? {1'b1, 0...} : {1'b0, 1...}, i.e. 0x8000 / 0x7FFF at WIDTH 16.
  - Otherwise rsp_data = sum.
  - Register rsp_data, rsp_ovf and rsp_id; go to DONE.
- DONE:
  - rsp_valid = 1; rsp_data, rsp_ovf and rsp_id are stable.
  - On rsp_ready: go to IDLE and update last_grant to rsp_id.
- req_ready is 0 in every state except IDLE. Requesters keep valid asserted until they see ready.
- Operand changes after capture are ignored.
- A requester may drop valid before it is granted; no grant is issued for it.
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_ovf 0, rsp_id 0, last_grant 1.
- Reset asserted mid-operation abandons the transaction with no response. The requester must re-issue it.

## Timing
- Accept at cycle T (req_ready high) -> rsp_valid high from T+3.
- With rsp_ready held at 1: DONE lasts one cycle and the next grant can occur at T+4, so peak throughput is 1 op per 4 cycles.
- With rsp_ready low: DONE holds indefinitely and outputs stay stable. No requester is granted while DONE holds.
- Both requesters continuously valid -> grants alternate 0,1,0,1,...
- rsp_valid falls in the cycle after a rsp_ready handshake.

## Structure
- Shared package sub_pkg:
  - default WIDTH constant;
  - state enum {IDLE, NEG, ADD, DONE};
  - requester-id type (1 bit);
  - SAT_MAX/SAT_MIN constants derived from WIDTH.
- One sub-module, ones_cpl: WIDTH-bit bitwise inverter, purely combinational, instantiated once on the captured b.
- The adder, overflow logic and saturation stay inline.

## Test plan
- Single request: requester 0 sends a=0x0005, b=0x0003 -> req_ready=01 at T; at T+3 rsp_data=0x0002, rsp_ovf=0, rsp_id=0.
- Negative result: a=0x0000, b=0x0001 -> rsp_data=0xFFFF, ovf=0.
- Overflow with SAT=0: a=0x8000, b=0x0001 -> rsp_data=0x7FFF, ovf=1. Same inputs with SAT=1 -> rsp_data=0x8000, ovf=1. Also a=0x7FFF, b=0xFFFF with SAT=1 -> 0x7FFF, ovf=1.
- Contention: both valid continuously, rsp_ready=1 -> grants at T, T+4, T+8 go to ids 0, 1, 0. Responses carry the matching ids and differences.
- Backpressure: rsp_ready held 0 for 10 cycles in DONE -> rsp_* stable, req_ready stays 00. Release -> rsp_valid drops the next cycle and the other requester is granted.
- Reset mid-op: assert rst during NEG -> outputs return to their reset values immediately. After release, the re-issued request completes with the correct result and no stale response appears.
